// File: rtl/im_loader_if.sv
// rtl/im_loader_if.sv - byte stream, control and instruction-memory write port of im_loader
interface im_loader_if #(
  parameter int ADDR_W = 16
);
  logic              byte_vld;
  logic [7:0]        byte_in;
  logic              load_req;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [15:0]       wdata;
  logic              cpu_rst_n;
  logic              busy;
  logic              done;
  logic              err;

  // master: the side supplying bytes and load requests
  modport master (
    output byte_vld, byte_in, load_req,
    input  we, waddr, wdata, cpu_rst_n, busy, done, err
  );

  // slave: the loader itself
  modport slave (
    input  byte_vld, byte_in, load_req,
    output we, waddr, wdata, cpu_rst_n, busy, done, err
  );
endinterface

// File: rtl/im_loader.sv
// rtl/im_loader.sv - boot-time framed byte loader into instruction memory
module im_loader #(
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                TIMEOUT   = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  im_loader_if.slave  bus
);

  // idle counter only has to reach TIMEOUT-2 (see timeout_hit)
  localparam int IDLE_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_CNT_HI,
    S_CNT_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_CHECK,
    S_DONE,
    S_ERR
  } state_t;

  state_t            state;
  state_t            state_n;
  logic [7:0]        cnt_hi;
  logic [15:0]       remaining;
  logic [7:0]        hi_byte;
  logic [7:0]        xor_acc;
  logic [ADDR_W-1:0] addr;
  logic [IDLE_W-1:0] idle_cnt;

  logic in_frame;
  logic take;
  logic wr_fire;
  logic timeout_hit;

  // qualify the strobe: load_req wins, bytes in DONE/ERR are ignored
  always_comb begin
    in_frame    = (state == S_CNT_LO) || (state == S_DATA_HI) ||
                  (state == S_DATA_LO) || (state == S_CHECK);
    take        = bus.byte_vld && !bus.load_req &&
                  (in_frame || (state == S_CNT_HI));
    wr_fire     = take && (state == S_DATA_LO);
    // registered err then lands exactly TIMEOUT cycles after the last strobe
    timeout_hit = in_frame && !bus.byte_vld && !bus.load_req &&
                  (idle_cnt == IDLE_W'(TIMEOUT - 2));
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_CNT_HI;
    end else begin
      state <= state_n;
    end
  end

  // next-state decode
  always_comb begin
    state_n = state;
    if (bus.load_req) begin
      state_n = S_CNT_HI;
    end else if (timeout_hit) begin
      state_n = S_ERR;
    end else if (take) begin
      case (state)
        S_CNT_HI:  state_n = S_CNT_LO;
        S_CNT_LO:  state_n = ({cnt_hi, bus.byte_in} == 16'd0) ? S_CHECK : S_DATA_HI;
        S_DATA_HI: state_n = S_DATA_LO;
        S_DATA_LO: state_n = (remaining == 16'd1) ? S_CHECK : S_DATA_HI;
        S_CHECK:   state_n = (bus.byte_in == xor_acc) ? S_DONE : S_ERR;
        default:   state_n = state;
      endcase
    end
  end

  // frame datapath: count, held high byte, running XOR, address, idle timer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_hi    <= 8'd0;
      remaining <= 16'd0;
      hi_byte   <= 8'd0;
      xor_acc   <= 8'd0;
      addr      <= BASE_ADDR;
      idle_cnt  <= '0;
    end else if (bus.load_req) begin
      xor_acc  <= 8'd0;
      addr     <= BASE_ADDR;
      idle_cnt <= '0;
    end else begin
      if (take || !in_frame) begin
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + 1'b1;
      end
      if (take) begin
        // first byte of a frame restarts the checksum
        xor_acc <= (state == S_CNT_HI) ? bus.byte_in : (xor_acc ^ bus.byte_in);
      end
      if (take && (state == S_CNT_HI)) begin
        cnt_hi <= bus.byte_in;
      end
      if (take && (state == S_CNT_LO)) begin
        remaining <= {cnt_hi, bus.byte_in};
      end
      if (take && (state == S_DATA_HI)) begin
        hi_byte <= bus.byte_in;
      end
      if (wr_fire) begin
        addr      <= addr + 1'b1;
        remaining <= remaining - 16'd1;
      end
    end
  end

  // registered memory write port, one pulse per completed word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.we    <= 1'b0;
      bus.waddr <= BASE_ADDR;
      bus.wdata <= 16'd0;
    end else begin
      bus.we <= wr_fire;
      if (wr_fire) begin
        bus.waddr <= addr;
        bus.wdata <= {hi_byte, bus.byte_in};
      end
    end
  end

  // registered status outputs decoded from the state being entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.cpu_rst_n <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.err       <= 1'b0;
    end else begin
      bus.cpu_rst_n <= (state_n == S_DONE);
      bus.done      <= (state_n == S_DONE);
      bus.err       <= (state_n == S_ERR);
      bus.busy      <= (state_n == S_CNT_LO) || (state_n == S_DATA_HI) ||
                       (state_n == S_DATA_LO) || (state_n == S_CHECK);
    end
  end

endmodule
